alu_sequencer: RTL
==================

# alu_sequencer

Issue-and-writeback stage that sits directly upstream of the 15-bit sign-in-MSB ALU. It owns an 8-entry operand register file and accepts one instruction at a time over a valid/ready handshake. For each instruction it reads two registers, drives the ALU's A/B/command inputs, waits a fixed number of cycles, captures the 15-bit result and writes it back to the destination register. Command 7, which the ALU leaves unused, is a load-immediate handled entirely inside this block.

## Interface
Parameters:
- ALU_LATENCY, 1: cycles `alu_res` needs after `alu_a`/`alu_b`/`alu_cmd` change (legal range 1..15).
- NREGS, 8: register count; the address width is fixed at 3.

Ports (clock and reset are fixed: one clock, `rst` is synchronous and active-high):
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept an instruction.
- in_cmd  in  3  0 ADD, 1 SUB, 2 AND, 3 MP0, 4 MP1, 5 DV0, 6 DV1, 7 LDI.
- in_rd, in_rs1, in_rs2  in  3 each  destination and source register indices.
- in_imm  in  16  immediate, used by LDI only.
- alu_a, alu_b  out  16  operand words to the ALU; bit 0 is unused, bits [15:1] carry the value.
- alu_cmd  out  3  ALU command.
- alu_res  in  15  ALU result.
- done  out  1  one-cycle pulse when a write-back happens.
- done_rd  out  3  register just written; valid while `done` is high.
- done_data  out  16  word just written; valid while `done` is high.
- err  out  1  one-cycle pulse when an instruction is dropped because of a zero divisor.

## Operation
- Word format: a 16-bit register word holds a 15-bit ALU value in bits [15:1]; bit 0 is forced to 0 on every ALU write-back.
- Operand routing: `alu_a` = R[rs1] and `alu_b` = R[rs2]. SUB therefore yields B−A, and DV0/DV1 yield B mod A and B / A.
- Write-back value for commands 0..6 is {alu_res, 1'b0}. For LDI, R[rd] = in_imm verbatim, including bit 0.
- Zero divisor: for cmd 5 or 6, the instruction is dropped if R[rs1][15:1] is 15'h0000 or 15'h7FFF, since the ALU maps both to zero.
  - No write-back occurs and `done` stays low.
  - `err` pulses in the cycle where WB would have occurred.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: `in_ready`=1. On in_valid&in_ready, latch cmd/rd/rs1/rs2/imm. Go to READ, or to WB if cmd=7.
  - READ: read the register file; register `alu_a`, `alu_b` and `alu_cmd`; load the EXEC counter with ALU_LATENCY−1. Go to EXEC.
  - EXEC: count down; at count 0, sample `alu_res` into the result register and go to WB.
  - WB: write R[rd] (or pulse `err`), pulse `done`, go to IDLE.
- `in_ready` is high only in IDLE. If `in_valid` is held while the block is busy, nothing is accepted and nothing is lost.
- `alu_a`, `alu_b` and `alu_cmd` hold their last values outside READ/EXEC.
- Reset (any state, mid-instruction included):
  - state goes to IDLE;
  - all registers, `alu_a`, `alu_b`, `alu_cmd` and `done_data` go to 0;
  - `done`, `err` and `done_rd` go to 0;
  - an in-flight instruction is discarded with no write-back.
- `in_ready` is 1 in the first cycle after reset deasserts.

## Timing
- Accept edge is T0.
  - ALU commands: READ in cycle 1; EXEC in cycles 2..1+ALU_LATENCY; WB in cycle 2+ALU_LATENCY (`done` high, register written at the end of that cycle); `in_ready` high again in cycle 3+ALU_LATENCY.
  - LDI: WB in cycle 1; `in_ready` high in cycle 2.
- Throughput: one instruction per 3+ALU_LATENCY cycles (per 2 cycles for LDI).
- A write completes before the next READ, so no forwarding is needed.

## Structure
- Shared package `alu_pkg` holds:
  - command constants CMD_ADD..CMD_DV1 and CMD_LDI=7;
  - the FSM state enum;
  - the zero-divisor pattern constants.
  The ALU and this block both use the command constants.
- One sub-module, `alu_regfile`: NREGS×16, two combinational read ports, one synchronous write port, synchronous clear on `rst`.

## Test plan
- LDI R1=0x0006, LDI R2=0x000A, then ADD rd=3 rs1=1 rs2=2 with a stub ALU returning A+B -> `done` at cycle 3, done_rd=3, done_data=0x0010; `in_ready` low during cycles 1..3.
- SUB rs1=R1 (0x0006), rs2=R2 (0x000A) -> `alu_cmd`=1, `alu_a`=0x0006, `alu_b`=0x000A; stub returns 2 -> R[rd]=0x0004.
- DV1 with R1=0x0000, and separately with R1=0xFFFE -> `err` pulse at cycle 3, no `done`, R[rd] unchanged.
- ALU_LATENCY=3, ADD accepted at T0 -> `alu_res` sampled at the end of cycle 4, `done` in cycle 5, `in_ready` in cycle 6.
- `in_valid` held high with 3 back-to-back instructions -> exactly 3 `done` pulses, each accept only when `in_ready`=1, in order.
- `rst` asserted in EXEC -> next cycle `in_ready`=1, `done`=0, all registers read 0, no write-back.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 15-bit sign-in-MSB ALU and its issue/writeback
// sequencer: command encodings, sequencer FSM states and the two operand
// patterns the ALU treats as a zero divisor.
package alu_pkg;

   // ALU command encodings; CMD_LDI is never sent to the ALU
   localparam logic [2:0] CMD_ADD = 3'd0;
   localparam logic [2:0] CMD_SUB = 3'd1;
   localparam logic [2:0] CMD_AND = 3'd2;
   localparam logic [2:0] CMD_MP0 = 3'd3;
   localparam logic [2:0] CMD_MP1 = 3'd4;
   localparam logic [2:0] CMD_DV0 = 3'd5;
   localparam logic [2:0] CMD_DV1 = 3'd6;
   localparam logic [2:0] CMD_LDI = 3'd7;

   // Register-file geometry
   localparam int unsigned REG_AW = 3;
   localparam int unsigned REG_DW = 16;

   // Both +0 and -0 (all ones in sign-in-MSB) are a zero divisor for the ALU
   localparam logic [14:0] DIVZ_POS = 15'h0000;
   localparam logic [14:0] DIVZ_NEG = 15'h7FFF;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_EXEC = 2'd2,
      S_WB   = 2'd3
   } seq_state_e;

   // True for the two divide commands
   function automatic logic is_div_cmd(input logic [2:0] cmd);
      return (cmd == CMD_DV0) || (cmd == CMD_DV1);
   endfunction

   // True when a 15-bit ALU value is one of the two zero encodings
   function automatic logic is_zero_divisor(input logic [14:0] value);
      return (value == DIVZ_POS) || (value == DIVZ_NEG);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: NREGS x 16-bit words, two combinational read ports,
// one synchronous write port, synchronous clear on rst.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int unsigned NREGS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we_i,
   input  logic [REG_AW-1:0]   waddr_i,
   input  logic [REG_DW-1:0]   wdata_i,
   input  logic [REG_AW-1:0]   raddr1_i,
   input  logic [REG_AW-1:0]   raddr2_i,
   output logic [REG_DW-1:0]   rdata1_o,
   output logic [REG_DW-1:0]   rdata2_o
);

   logic [REG_DW-1:0] mem_q [NREGS];

   // Combinational read ports; addresses past NREGS read as zero
   always_comb begin
      rdata1_o = 16'h0000;
      rdata2_o = 16'h0000;
      if (32'(raddr1_i) < NREGS) begin
         rdata1_o = mem_q[raddr1_i];
      end else begin
         rdata1_o = 16'h0000;
      end
      if (32'(raddr2_i) < NREGS) begin
         rdata2_o = mem_q[raddr2_i];
      end else begin
         rdata2_o = 16'h0000;
      end
   end

   // Synchronous clear and single write port
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            mem_q[i] <= 16'h0000;
         end
      end else if (we_i && (32'(waddr_i) < NREGS)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Issue-and-writeback stage in front of the 15-bit ALU. Accepts one
// instruction at a time, reads two operands, drives the ALU for a fixed
// latency, writes the result back. LDI is handled locally; divides by a
// zero encoding are dropped with an err pulse instead of a write-back.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned ALU_LATENCY = 1,
   parameter int unsigned NREGS       = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_cmd,
   input  logic [2:0]  in_rd,
   input  logic [2:0]  in_rs1,
   input  logic [2:0]  in_rs2,
   input  logic [15:0] in_imm,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [2:0]  alu_cmd,
   input  logic [14:0] alu_res,
   output logic        done,
   output logic [2:0]  done_rd,
   output logic [15:0] done_data,
   output logic        err
);

   // EXEC counts down from here to zero, giving ALU_LATENCY EXEC cycles
   localparam logic [3:0] EXEC_LOAD = 4'(ALU_LATENCY - 1);

   seq_state_e  state_q;
   logic [2:0]  cmd_q;
   logic [2:0]  rd_q;
   logic [2:0]  rs1_q;
   logic [2:0]  rs2_q;
   logic [3:0]  cnt_q;
   logic        divz_q;
   logic [15:0] alu_a_q;
   logic [15:0] alu_b_q;
   logic [2:0]  alu_cmd_q;
   logic        in_ready_q;
   logic        done_q;
   logic [2:0]  done_rd_q;
   logic [15:0] done_data_q;
   logic        err_q;

   logic [15:0] rs1_data_s;
   logic [15:0] rs2_data_s;

   // The write port is driven straight from the registered done outputs, so
   // the register updates at the end of the WB cycle in which done is high.
   alu_regfile #(
      .NREGS (NREGS)
   ) u_rf (
      .clk      (clk),
      .rst      (rst),
      .we_i     (done_q),
      .waddr_i  (done_rd_q),
      .wdata_i  (done_data_q),
      .raddr1_i (rs1_q),
      .raddr2_i (rs2_q),
      .rdata1_o (rs1_data_s),
      .rdata2_o (rs2_data_s)
   );

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cmd_q       <= 3'd0;
         rd_q        <= 3'd0;
         rs1_q       <= 3'd0;
         rs2_q       <= 3'd0;
         cnt_q       <= 4'd0;
         divz_q      <= 1'b0;
         alu_a_q     <= 16'h0000;
         alu_b_q     <= 16'h0000;
         alu_cmd_q   <= 3'd0;
         in_ready_q  <= 1'b1;
         done_q      <= 1'b0;
         done_rd_q   <= 3'd0;
         done_data_q <= 16'h0000;
         err_q       <= 1'b0;
      end else begin
         // Pulses default low; the transition into WB raises one of them
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  cmd_q      <= in_cmd;
                  rd_q       <= in_rd;
                  rs1_q      <= in_rs1;
                  rs2_q      <= in_rs2;
                  in_ready_q <= 1'b0;
                  if (in_cmd == CMD_LDI) begin
                     // Immediate is written verbatim, bit 0 included
                     done_q      <= 1'b1;
                     done_rd_q   <= in_rd;
                     done_data_q <= in_imm;
                     state_q     <= S_WB;
                  end else begin
                     state_q <= S_READ;
                  end
               end
            end
            S_READ: begin
               alu_a_q   <= rs1_data_s;
               alu_b_q   <= rs2_data_s;
               alu_cmd_q <= cmd_q;
               cnt_q     <= EXEC_LOAD;
               divz_q    <= is_div_cmd(cmd_q) && is_zero_divisor(rs1_data_s[15:1]);
               state_q   <= S_EXEC;
            end
            S_EXEC: begin
               if (cnt_q == 4'd0) begin
                  if (divz_q) begin
                     err_q <= 1'b1;
                  end else begin
                     done_q      <= 1'b1;
                     done_rd_q   <= rd_q;
                     done_data_q <= {alu_res, 1'b0};
                  end
                  state_q <= S_WB;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_WB: begin
               in_ready_q <= 1'b1;
               state_q    <= S_IDLE;
            end
            default: begin
               in_ready_q <= 1'b1;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_cmd   = alu_cmd_q;
   assign done      = done_q;
   assign done_rd   = done_rd_q;
   assign done_data = done_data_q;
   assign err       = err_q;

endmodule
